hex_scroll_ctrl: RTL and testbench

Controller that sequences the 7-segment character decode path across all six board HEX displays. Holds an 8-slot character message buffer and a prescaled scroll timer. Rotates a 6-character window over the buffer, left or right, under switch control. Sits between board switches/keys and to_HEX0..to_HEX5, replacing direct static drive of a single digit.

---
 rtl/hex_scroll_ctrl_if.sv | 27 ++
 rtl/hex_scroll_ctrl.sv | 131 +++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_scroll_ctrl_if.sv
// Switch/key controls and HEX/LED display drive for hex_scroll_ctrl.
// The board-side block drives the controls; the controller drives the displays.
interface hex_scroll_ctrl_if;
    logic       fr_run;
    logic       fr_dir;
    logic       fr_clear;
    logic       fr_wr_en;
    logic [2:0] fr_wr_addr;
    logic [2:0] fr_wr_char;
    logic [7:0] to_HEX0;
    logic [7:0] to_HEX1;
    logic [7:0] to_HEX2;
    logic [7:0] to_HEX3;
    logic [7:0] to_HEX4;
    logic [7:0] to_HEX5;
    logic [9:0] to_LEDR;

    modport master (
        output fr_run, fr_dir, fr_clear, fr_wr_en, fr_wr_addr, fr_wr_char,
        input  to_HEX0, to_HEX1, to_HEX2, to_HEX3, to_HEX4, to_HEX5, to_LEDR
    );

    modport slave (
        input  fr_run, fr_dir, fr_clear, fr_wr_en, fr_wr_addr, fr_wr_char,
        output to_HEX0, to_HEX1, to_HEX2, to_HEX3, to_HEX4, to_HEX5, to_LEDR
    );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a 6-character window over an 8-slot message buffer onto HEX5..HEX0,
// stepping the window once every TICK_DIV clocks while scrolling is enabled.
module hex_scroll_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic              fr_CLOCK_50,
    input  logic              fr_KEY0,
    hex_scroll_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_BLANK  = 2'b00,
        ST_HOLD   = 2'b01,
        ST_SCROLL = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [2:0]         offset_q, offset_d;
    logic [2:0]         msg_q [8];
    logic [7:0]         hex_q [6];
    logic [7:0]         hex_d [6];
    logic               terminal;

    assign terminal = (cnt_q == CNT_W'(TICK_DIV - 1));

    function automatic logic [7:0] seg_of(input logic [2:0] code);
        case (code)
            3'd0:    seg_of = 8'hA1;
            3'd1:    seg_of = 8'h86;
            3'd2:    seg_of = 8'hF9;
            3'd3:    seg_of = 8'hC0;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    // State register
    always_ff @(posedge fr_CLOCK_50 or negedge fr_KEY0) begin
        if (!fr_KEY0) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.fr_clear) begin
            state_d = ST_BLANK;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (bus.fr_run)
                        state_d = ST_SCROLL;
                    else if (bus.fr_wr_en)
                        state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.fr_run)
                        state_d = ST_SCROLL;
                end
                ST_SCROLL: begin
                    if (!bus.fr_run)
                        state_d = ST_HOLD;
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // Output/datapath logic: prescaler only runs while scrolling stays enabled,
    // so dropping fr_run on the terminal count suppresses that tick.
    always_comb begin
        cnt_d    = '0;
        tick_d   = 1'b0;
        offset_d = offset_q;
        if (bus.fr_clear) begin
            offset_d = 3'd0;
        end else if (state_q == ST_SCROLL && bus.fr_run) begin
            if (terminal) begin
                tick_d   = 1'b1;
                offset_d = bus.fr_dir ? (offset_q - 3'd1) : (offset_q + 3'd1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_window
            logic [2:0] slot;
            assign slot      = offset_q + 3'(5 - gi);
            assign hex_d[gi] = (state_q == ST_BLANK) ? 8'hFF : seg_of(msg_q[slot]);
        end
    endgenerate

    always_ff @(posedge fr_CLOCK_50 or negedge fr_KEY0) begin
        if (!fr_KEY0) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            offset_q <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                msg_q[i] <= (i < 4) ? 3'(i) : 3'd4;
            end
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= 8'hFF;
            end
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            offset_q <= offset_d;
            // A write coinciding with clear is dropped.
            if (bus.fr_wr_en && !bus.fr_clear) begin
                msg_q[bus.fr_wr_addr] <= bus.fr_wr_char;
            end
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign bus.to_HEX0 = hex_q[0];
    assign bus.to_HEX1 = hex_q[1];
    assign bus.to_HEX2 = hex_q[2];
    assign bus.to_HEX3 = hex_q[3];
    assign bus.to_HEX4 = hex_q[4];
    assign bus.to_HEX5 = hex_q[5];
    assign bus.to_LEDR = {4'b0000, tick_q, state_q, offset_q};
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Scoreboard bench for hex_scroll_ctrl: directed scenarios plus random stimulus,
// with expected displays produced by a rule-level model of the scroller.
module tb_hex_scroll_ctrl;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_scroll_ctrl_if bus();

    hex_scroll_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .fr_CLOCK_50 (clk),
        .fr_KEY0     (rst_n),
        .bus         (bus)
    );

    typedef struct packed {
        logic [47:0] hex;
        logic [9:0]  ledr;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Model: 0 = blank, 1 = hold, 2 = scroll
    int          m_state, m_off, m_cnt, m_tick;
    int          m_buf [8];
    logic [47:0] m_hex;
    logic [7:0]  seg_lut [8] = '{8'hA1, 8'h86, 8'hF9, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    function automatic logic [47:0] window();
        logic [47:0] w;
        w = '0;
        for (int k = 0; k < 6; k++) begin
            w[k*8 +: 8] = seg_lut[m_buf[(m_off + 5 - k) % 8]];
        end
        return w;
    endfunction

    function automatic logic [47:0] dut_hex();
        return {bus.to_HEX5, bus.to_HEX4, bus.to_HEX3, bus.to_HEX2, bus.to_HEX1, bus.to_HEX0};
    endfunction

    task automatic model_reset();
        m_state = 0; m_off = 0; m_cnt = 0; m_tick = 0;
        m_buf   = '{0, 1, 2, 3, 4, 4, 4, 4};
        m_hex   = {48{1'b1}};
    endtask

    task automatic model_edge(input bit run, input bit dir, input bit clr, input bit we,
                              input int wa, input int wc);
        logic [47:0] shown;
        shown = (m_state == 0) ? {48{1'b1}} : window();
        if (clr) begin
            m_state = 0; m_off = 0; m_cnt = 0; m_tick = 0;
        end else begin
            if (we) m_buf[wa] = wc;
            m_tick = 0;
            case (m_state)
                0: begin
                    if (run) m_state = 2;
                    else if (we) m_state = 1;
                    m_cnt = 0;
                end
                1: begin
                    if (run) m_state = 2;
                    m_cnt = 0;
                end
                default: begin
                    if (!run) begin
                        m_state = 1; m_cnt = 0;
                    end else if (m_cnt == TD - 1) begin
                        m_cnt = 0; m_tick = 1;
                        m_off = (m_off + (dir ? 7 : 1)) % 8;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
        end
        m_hex = shown;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input bit run, input bit dir, input bit clr, input bit we,
                        input int wa, input int wc);
        exp_t e;
        bus.fr_run     = run;
        bus.fr_dir     = dir;
        bus.fr_clear   = clr;
        bus.fr_wr_en   = we;
        bus.fr_wr_addr = 3'(wa);
        bus.fr_wr_char = 3'(wc);
        @(posedge clk);
        #1;
        model_edge(run, dir, clr, we, wa, wc);
        e.hex  = m_hex;
        e.ledr = {4'b0000, 1'(m_tick), 2'(m_state), 3'(m_off)};
        sb_q.push_back(e);
    endtask

    // Reset is applied and checked between clock edges.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_hex", 64'(dut_hex()), 64'({48{1'b1}}));
        chk("async_reset_ledr", 64'(bus.to_LEDR), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                checks++;
                if (dut_hex() !== e.hex || bus.to_LEDR !== e.ledr) begin
                    errors++;
                    $display("FAIL txn %0d hex got %h expected %h ledr got %h expected %h",
                             txn, dut_hex(), e.hex, bus.to_LEDR, e.ledr);
                end else begin
                    $display("txn %0d ok hex=%h ledr=%h", txn, e.hex, e.ledr);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        bus.fr_run = 1'b0; bus.fr_dir = 1'b0; bus.fr_clear = 1'b0;
        bus.fr_wr_en = 1'b0; bus.fr_wr_addr = 3'd0; bus.fr_wr_char = 3'd0;
        model_reset();
        do_reset();

        // Write wakes the display into hold
        step(0, 0, 0, 1, 4, 3);
        chk("tp1_state_hold", 64'(bus.to_LEDR), 64'h008);
        step(0, 0, 0, 0, 0, 0);
        chk("tp1_window", 64'(dut_hex()), 64'hA186F9C0C0FF);

        // Forward scroll and full wrap
        do_reset();
        repeat (5) step(1, 0, 0, 0, 0, 0);
        chk("tp2_first_tick_ledr", 64'(bus.to_LEDR), 64'h031);
        step(1, 0, 0, 0, 0, 0);
        chk("tp2_hex5_after_tick", 64'(bus.to_HEX5), 64'h86);
        repeat (27) step(1, 0, 0, 0, 0, 0);
        chk("tp2_wrap_ledr", 64'(bus.to_LEDR), 64'h030);
        step(1, 0, 0, 0, 0, 0);
        chk("tp2_wrap_window", 64'(dut_hex()), 64'hA186F9C0FFFF);

        // Backward scroll from offset 0
        do_reset();
        repeat (5) step(1, 1, 0, 0, 0, 0);
        chk("tp3_offset7_ledr", 64'(bus.to_LEDR), 64'h037);
        step(1, 1, 0, 0, 0, 0);
        chk("tp3_hex5_hex4", 64'({bus.to_HEX5, bus.to_HEX4}), 64'hFFA1);

        // Partial period discarded on run drop
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("tp4_hold_no_tick", 64'(bus.to_LEDR), 64'h008);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        chk("tp4_hold_offset_kept", 64'(bus.to_LEDR), 64'h008);
        n = 0;
        do begin
            step(1, 0, 0, 0, 0, 0);
            n++;
        end while (!bus.to_LEDR[5] && n < 12);
        chk("tp4_tick_gap", 64'(n), 64'd5);
        chk("tp4_tick_ledr", 64'(bus.to_LEDR), 64'h031);

        // Run falling on the terminal count
        do_reset();
        repeat (4) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("tp4_run_drop_terminal", 64'(bus.to_LEDR), 64'h008);

        // Clear beats a same-cycle write
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 2);
        chk("tp5_clear_ledr", 64'(bus.to_LEDR), 64'h000);
        step(0, 0, 0, 1, 6, 4);
        step(0, 0, 0, 0, 0, 0);
        chk("tp5_slot0_kept", 64'(bus.to_HEX5), 64'hA1);

        // Async reset undoes an earlier write
        step(1, 0, 0, 1, 0, 2);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 1, 6, 4);
        step(0, 0, 0, 0, 0, 0);
        chk("tp6_write_undone", 64'(bus.to_HEX5), 64'hA1);

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
